pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the instruction-fetch path. It builds the four next-PC candidates (sequential, jump, call, return) and the select code for the downstream 4:1 five-bit next-PC mux. It registers the mux result as the current PC and keeps a 4-entry return-address stack for CALL/RET. A small FSM handles the post-reset boot cycle and stack faults, so fetch never runs from a corrupted return address.

## Interface
Parameters:
- DEPTH, 4, return-stack entries; fixed at 4 for this design, and depth is 3 bits wide.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; 0 = stall, PC holds.
- op  in  2  0 SEQ, 1 JUMP, 2 CALL, 3 RET.
- target  in  5  jump/call destination.
- clr_fault  in  1  leaves FAULT state.
- mux_sel  out  2  select for next-PC mux; equals op, combinational.
- mux_a  out  5  pc+1 mod 32.
- mux_b  out  5  target (JUMP path).
- mux_c  out  5  target (CALL path).
- mux_d  out  5  return-stack top; 0 when empty.
- mux_y  in  5  selected next PC returned from the mux.
- pc  out  5  current PC, registered.
- pc_valid  out  1  1 only in RUN.
- depth  out  3  return-stack occupancy, 0..4.
- fault  out  2  bit0 = overflow (CALL at depth 4), bit1 = underflow (RET at depth 0); sticky.

## Operation
- Reset values (async, immediate): pc=0, depth=0, all stack entries=0, fault=00, state=BOOT, pc_valid=0.
- FSM states: BOOT, RUN, FAULT.
  - BOOT → RUN unconditionally after one clock.
  - RUN → FAULT on a faulting op with en=1.
  - FAULT → RUN on clr_fault=1.
- BOOT:
  - pc holds 0.
  - en and op are ignored.
- RUN, en=1, no fault:
  - pc <= mux_y.
  - CALL pushes pc+1 mod 32 and increments depth.
  - RET pops and decrements depth.
  - SEQ and JUMP leave the stack unchanged.
- RUN, en=0:
  - pc, stack and depth hold.
  - Fault checks are not performed.
- Overflow: CALL with en=1 at depth=4 sets fault[0] and moves to FAULT. pc, stack and depth are not updated.
- Underflow: RET with en=1 at depth=0 sets fault[1] and moves to FAULT. pc is not updated.
- FAULT:
  - pc_valid=0.
  - pc, stack and depth hold.
  - en and op are ignored.
  - clr_fault=1 clears fault to 00 and moves to RUN on the next edge. Stack contents are preserved.
- Arithmetic: all PC values are 5-bit unsigned.
  - pc+1 wraps 31→0.
  - A pushed return address of 31+1 is stored as 0.
- Stack is LIFO; mux_d always shows entry[depth-1].
- mux_a..mux_d and mux_sel are driven in every state. Their values only matter when an update occurs.

## Timing
- Combinational path: op/target/stack → mux inputs → mux_y → pc D-input. The whole path closes within one cycle.
- Latency: an op presented with en=1 in RUN takes effect on pc at the next rising edge.
- Boot: after rst_n deasserts, the first edge enters RUN. pc_valid rises then, and pc=0 is the first fetched address.
- depth and the pushed/popped entry update on the same edge as pc.
- Fault detection and the fault flag assert on the same edge that would have updated pc; pc_valid drops on that edge.
- clr_fault is sampled only in FAULT and ignored otherwise. pc_valid returns to 1 on the edge that samples clr_fault=1.
- rst_n low mid-operation immediately forces all reset values, regardless of state or clock.

## Test plan
- Reset, release, then SEQ with en=1 for 4 cycles → pc_valid 0 for 1 cycle, then 1; pc=0,1,2,3; mux_sel=0.
- JUMP target=30, then SEQ ×2 → pc=30, 31, then 0 (wrap); depth stays 0.
- At pc=3: CALL target=10 → pc=10, depth=1, mux_d=4. Then RET → pc=4, depth=0.
- Nested CALLs at pc=0,1,2,3 with targets 1,2,3,4 → depth=4. A fifth CALL → fault=01, pc_valid=0, pc stays 4; hold 3 cycles with en=1, no change. Then clr_fault=1 → RUN, fault=00, depth=4, mux_d=4.
- RET at depth=0 → fault=10, pc held. Then en=0 with clr_fault=1 → RUN next edge. Then RET with en=0 → no fault, no change.
- At depth=2 mid-run, pulse rst_n low between clock edges → pc=0, depth=0, fault=00, pc_valid=0 immediately. BOOT lasts one cycle after release.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-path bundle between the PC sequencer and its next-PC mux environment.
// The sequencer drives the four mux candidates and the select code.
// The environment returns the selected value on mux_y, alongside the control inputs.
interface pc_sequencer_if;
  logic       en;
  logic [1:0] op;
  logic [4:0] target;
  logic       clr_fault;
  logic [1:0] mux_sel;
  logic [4:0] mux_a;
  logic [4:0] mux_b;
  logic [4:0] mux_c;
  logic [4:0] mux_d;
  logic [4:0] mux_y;
  logic [4:0] pc;
  logic       pc_valid;
  logic [2:0] depth;
  logic [1:0] fault;

  modport slave (
    input  en, op, target, clr_fault, mux_y,
    output mux_sel, mux_a, mux_b, mux_c, mux_d, pc, pc_valid, depth, fault
  );

  modport master (
    output en, op, target, clr_fault, mux_y,
    input  mux_sel, mux_a, mux_b, mux_c, mux_d, pc, pc_valid, depth, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: builds the next-PC candidates and holds the current PC.
// It also keeps a 4-entry return-address stack and guards fetch against stack faults.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | one cycle after reset; pc held at 0, inputs ignored
// ST_RUN   | normal fetch; pc_valid=1, ops applied when en=1
// ST_FAULT | stack over/underflow seen; everything held until clr_fault
module pc_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] OP_SEQ  = 2'd0;
  localparam logic [1:0] OP_JUMP = 2'd1;
  localparam logic [1:0] OP_CALL = 2'd2;
  localparam logic [1:0] OP_RET  = 2'd3;

  localparam logic [2:0] DEPTH_FULL = 3'(DEPTH);

  state_t     state_q, state_d;
  logic [4:0] pc_q;
  logic [2:0] depth_q;
  logic [1:0] fault_q;
  logic [4:0] stack_q [DEPTH];

  logic       pc_upd;
  logic       push;
  logic       pop;
  logic       set_ovf;
  logic       set_unf;
  logic       clr;
  logic [1:0] top_idx;
  logic [4:0] pc_inc;

  // Top-of-stack index; at depth 4 the low bits wrap to 0, so minus one lands on entry 3.
  assign top_idx = depth_q[1:0] - 2'd1;
  assign pc_inc  = pc_q + 5'd1;

  // Mux candidates are driven in every state; the select code simply follows op.
  assign bus.mux_sel  = bus.op;
  assign bus.mux_a    = pc_inc;
  assign bus.mux_b    = bus.target;
  assign bus.mux_c    = bus.target;
  assign bus.mux_d    = (depth_q == 3'd0) ? 5'd0 : stack_q[top_idx];
  assign bus.pc       = pc_q;
  assign bus.pc_valid = (state_q == ST_RUN);
  assign bus.depth    = depth_q;
  assign bus.fault    = fault_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes; fault checks apply only while advancing in RUN.
  always_comb begin
    state_d = state_q;
    pc_upd  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.en) begin
          case (bus.op)
            OP_CALL: begin
              if (depth_q == DEPTH_FULL) begin
                set_ovf = 1'b1;
                state_d = ST_FAULT;
              end else begin
                pc_upd = 1'b1;
                push   = 1'b1;
              end
            end
            OP_RET: begin
              if (depth_q == 3'd0) begin
                set_unf = 1'b1;
                state_d = ST_FAULT;
              end else begin
                pc_upd = 1'b1;
                pop    = 1'b1;
              end
            end
            OP_SEQ, OP_JUMP: pc_upd = 1'b1;
            default: pc_upd = 1'b0;
          endcase
        end
      end
      ST_FAULT: begin
        if (bus.clr_fault) begin
          clr     = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // PC, depth and sticky fault flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= 5'd0;
      depth_q <= 3'd0;
      fault_q <= 2'b00;
    end else begin
      if (pc_upd) pc_q <= bus.mux_y;
      if (push)     depth_q <= depth_q + 3'd1;
      else if (pop) depth_q <= depth_q - 3'd1;
      if (clr) fault_q <= 2'b00;
      else     fault_q <= fault_q | {set_unf, set_ovf};
    end
  end

  // Return-address stack; a pop only moves depth, so stale entries stay below the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= 5'd0;
    end else if (push) begin
      stack_q[depth_q[1:0]] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk through boot, wrap, call/return and both
// fault kinds, then a randomized stretch, all compared against a queue-based model.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_sequencer_if bus ();

  pc_sequencer #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The external next-PC mux that the sequencer feeds.
  always_comb begin
    case (bus.mux_sel)
      2'd0:    bus.mux_y = bus.mux_a;
      2'd1:    bus.mux_y = bus.mux_b;
      2'd2:    bus.mux_y = bus.mux_c;
      default: bus.mux_y = bus.mux_d;
    endcase
  end

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  int m_pc;
  int m_fault;
  bit m_boot;
  bit m_halted;
  int m_stack[$];

  task automatic model_reset();
    m_pc     = 0;
    m_fault  = 0;
    m_boot   = 1'b1;
    m_halted = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_step(input bit e, input int o, input int t, input bit c);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      if (c) begin
        m_halted = 1'b0;
        m_fault  = 0;
      end
    end else if (e) begin
      case (o)
        0: m_pc = (m_pc + 1) % 32;
        1: m_pc = t;
        2: begin
          if (m_stack.size() == 4) begin
            m_fault  = m_fault | 1;
            m_halted = 1'b1;
          end else begin
            m_stack.push_back((m_pc + 1) % 32);
            m_pc = t;
          end
        end
        default: begin
          if (m_stack.size() == 0) begin
            m_fault  = m_fault | 2;
            m_halted = 1'b1;
          end else begin
            m_pc = m_stack.pop_back();
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    int exp_top;
    exp_top = (m_stack.size() == 0) ? 0 : m_stack[m_stack.size() - 1];
    chk({where, ".pc"},       32'(bus.pc),       32'(m_pc));
    chk({where, ".pc_valid"}, 32'(bus.pc_valid), 32'(!m_boot && !m_halted));
    chk({where, ".depth"},    32'(bus.depth),    32'(m_stack.size()));
    chk({where, ".fault"},    32'(bus.fault),    32'(m_fault));
    chk({where, ".mux_d"},    32'(bus.mux_d),    32'(exp_top));
    chk({where, ".mux_a"},    32'(bus.mux_a),    32'((m_pc + 1) % 32));
    chk({where, ".mux_sel"},  32'(bus.mux_sel),  32'(bus.op));
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, check at the next falling edge.
  task automatic cycle(input string where, input bit e, input int o, input int t, input bit c);
    bus.en        = e;
    bus.op        = 2'(o);
    bus.target    = 5'(t);
    bus.clr_fault = c;
    @(posedge clk);
    model_step(e, o, t, c);
    @(negedge clk);
    check_all(where);
  endtask

  // Asynchronous reset pulse placed strictly between clock edges.
  task automatic pulse_reset(input string where);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(where);
    #1;
    rst_n = 1'b1;
  endtask

  // Global time bound so a stuck run still reports and ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.op        = 2'd0;
    bus.target    = 5'd0;
    bus.clr_fault = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Boot cycle then sequential fetch.
    cycle("boot", 1, 0, 0, 0);
    chk("boot_valid", 32'(bus.pc_valid), 32'd1);
    for (int i = 0; i < 3; i++) cycle("seq", 1, 0, 0, 0);
    chk("seq_pc3", 32'(bus.pc), 32'd3);

    // Jump near the top of the address space and wrap.
    cycle("jump30", 1, 1, 30, 0);
    cycle("wrap31", 1, 0, 0, 0);
    cycle("wrap0",  1, 0, 0, 0);
    chk("wrap_pc0", 32'(bus.pc), 32'd0);

    // Reach pc=3, call and return.
    for (int i = 0; i < 3; i++) cycle("to3", 1, 0, 0, 0);
    cycle("call10", 1, 2, 10, 0);
    chk("call_mux_d", 32'(bus.mux_d), 32'd4);
    cycle("ret", 1, 3, 0, 0);
    chk("ret_pc4", 32'(bus.pc), 32'd4);

    // Nested calls to full depth, then overflow.
    cycle("jump0", 1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cycle("nest", 1, 2, i, 0);
    chk("nest_depth", 32'(bus.depth), 32'd4);
    cycle("ovf", 1, 2, 17, 0);
    chk("ovf_fault", 32'(bus.fault), 32'd1);
    for (int i = 0; i < 3; i++) cycle("ovf_hold", 1, $urandom_range(0, 3), $urandom_range(0, 31), 0);
    cycle("ovf_clr", 1, 3, 0, 1);
    chk("ovf_clr_mux_d", 32'(bus.mux_d), 32'd4);

    // Drain the stack and underflow.
    for (int i = 0; i < 4; i++) cycle("drain", 1, 3, 0, 0);
    cycle("unf", 1, 3, 0, 0);
    chk("unf_fault", 32'(bus.fault), 32'd2);
    cycle("unf_clr", 0, 0, 0, 1);
    cycle("ret_stall", 0, 3, 0, 0);
    chk("stall_fault", 32'(bus.fault), 32'd0);

    // clr_fault outside FAULT has no effect.
    cycle("clr_run", 1, 0, 0, 1);

    // Mid-run reset at depth 2, then one boot cycle.
    cycle("c1", 1, 2, 20, 0);
    cycle("c2", 1, 2, 25, 0);
    pulse_reset("midrst");
    cycle("reboot", 1, 1, 9, 0);
    cycle("after_boot", 1, 1, 9, 0);

    // Randomized stretch with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 131 == 70) pulse_reset("rnd_rst");
      cycle("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 31), $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
